// File: rtl/kmouse_pkg.sv
// Shared constants for the Kempston-style mouse port: address decode values,
// mode encoding and the delta-register saturation helper.
package kmouse_pkg;

    localparam logic [2:0] ADDR_X      = 3'b011;
    localparam logic [2:0] ADDR_Y      = 3'b111;
    localparam logic [1:0] ADDR_BTN_LO = 2'b10;    // buttons answer on x10

    typedef enum logic {
        MODE_ABS   = 1'b0,
        MODE_DELTA = 1'b1
    } kmouse_mode_e;

    localparam logic signed [8:0] DELTA_MAX = 9'sd127;
    localparam logic signed [8:0] DELTA_MIN = -9'sd128;

    function automatic logic signed [8:0] sat_delta(input logic signed [10:0] v);
        if (v > 11'(DELTA_MAX))
            return DELTA_MAX;
        else if (v < 11'(DELTA_MIN))
            return DELTA_MIN;
        else
            return v[8:0];
    endfunction

endpackage

// File: rtl/kmouse_axis.sv
// One mouse axis: wrapping position accumulator plus a saturating
// clear-on-read delta register fed by the same packet movement.
module kmouse_axis
    import kmouse_pkg::*;
#(
    parameter int CNT_W   = 12,
    parameter int SHIFT   = 0,
    parameter int INV     = 0,
    parameter int RST_VAL = 0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             i_event,
    input  logic             i_clear,
    input  logic signed [8:0] i_move,
    output logic [7:0]       o_abs,
    output logic [7:0]       o_delta
);

    localparam logic [CNT_W-1:0] ACC_RST = CNT_W'(RST_VAL) << SHIFT;

    logic [CNT_W-1:0]  r_acc;
    logic signed [8:0] r_delta;

    logic signed [9:0]  w_move;      // one bit wider so negating -256 cannot overflow
    logic signed [9:0]  w_move_sh;
    logic [CNT_W-1:0]   w_move_acc;
    logic signed [8:0]  w_delta_base;
    logic signed [10:0] w_delta_sum;
    logic signed [8:0]  w_delta_next;

    always_comb begin
        w_move = {i_move[8], i_move};
        if (INV != 0)
            w_move = -w_move;
    end

    assign w_move_sh  = w_move >>> SHIFT;
    assign w_move_acc = CNT_W'(w_move);

    // A read clears before the new packet adds, so a coincident packet survives.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_delta_base = i_clear ? 9'sd0 : r_delta;
        w_delta_sum  = 11'(w_delta_base) + 11'(w_move_sh);
        w_delta_next = w_delta_base;
        if (i_event)
            w_delta_next = sat_delta(w_delta_sum);
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_acc   <= ACC_RST;
            r_delta <= '0;
        end else begin
            if (i_event)
                r_acc <= r_acc + w_move_acc;
            r_delta <= w_delta_next;
        end
    end

    assign o_abs   = r_acc[SHIFT+7:SHIFT];
    assign o_delta = r_delta[7:0];

endmodule

// File: rtl/kmouse_port.sv
// Z80-readable mouse port fed by the HPS PS/2 packet stream: toggle detect,
// address decode, buttons byte and optional wheel counter (KMOUSE_WHEEL_EN).
module kmouse_port
    import kmouse_pkg::*;
#(
    parameter int CNT_W    = 12,
    parameter int SHIFT    = 0,
    parameter int INV_Y    = 0,
    parameter int RESET_DX = 128
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic [15:0] ps2_mouse_ext,
    input  logic        mode,
    input  logic [2:0]  addr,
    input  logic        rd,
    output logic        sel,
    output logic [7:0]  dout
);

    logic         r_toggle;
    logic         w_event;
    logic         w_hit_x;
    logic         w_hit_y;
    logic         w_hit_btn;
    kmouse_mode_e w_mode;
    logic [7:0]   w_x_abs, w_x_delta, w_y_abs, w_y_delta;
    logic [3:0]   w_wheel_nib;
    logic         w_unused;

    // Loading the copy during reset too means a toggle coinciding with reset is dropped.
    always_ff @(posedge clk_sys) begin
        r_toggle <= ps2_mouse[24];
    end

    assign w_event   = (ps2_mouse[24] ^ r_toggle) & ~reset;
    assign w_mode    = kmouse_mode_e'(mode);
    assign w_hit_x   = (addr == ADDR_X);
    assign w_hit_y   = (addr == ADDR_Y);
    assign w_hit_btn = (addr[1:0] == ADDR_BTN_LO);

    kmouse_axis #(
        .CNT_W(CNT_W), .SHIFT(SHIFT), .INV(0), .RST_VAL(RESET_DX)
    ) u_axis_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_event (w_event),
        .i_clear (rd && w_hit_x && (w_mode == MODE_DELTA)),
        .i_move  ({ps2_mouse[4], ps2_mouse[15:8]}),
        .o_abs   (w_x_abs),
        .o_delta (w_x_delta)
    );

    kmouse_axis #(
        .CNT_W(CNT_W), .SHIFT(SHIFT), .INV(INV_Y), .RST_VAL(0)
    ) u_axis_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_event (w_event),
        .i_clear (rd && w_hit_y && (w_mode == MODE_DELTA)),
        .i_move  ({ps2_mouse[5], ps2_mouse[23:16]}),
        .o_abs   (w_y_abs),
        .o_delta (w_y_delta)
    );

`ifdef KMOUSE_WHEEL_EN
    logic [3:0] r_wheel;

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_wheel <= '0;
        else if (w_event)
            r_wheel <= r_wheel + ps2_mouse_ext[3:0];
    end

    assign w_wheel_nib = r_wheel;
    assign w_unused    = &{1'b0, ps2_mouse[7:6], ps2_mouse[3], ps2_mouse_ext[15:4]};
`else
    assign w_wheel_nib = 4'hF;
    assign w_unused    = &{1'b0, ps2_mouse[7:6], ps2_mouse[3], ps2_mouse_ext};
`endif

    always_comb begin
        sel  = 1'b0;
        dout = 8'hFF;
        if (w_hit_x) begin
            sel  = 1'b1;
            dout = (w_mode == MODE_DELTA) ? w_x_delta : w_x_abs;
        end else if (w_hit_y) begin
            sel  = 1'b1;
            dout = (w_mode == MODE_DELTA) ? w_y_delta : w_y_abs;
        end else if (w_hit_btn) begin
            // Active-low buttons in {M, L, R} order, bit 3 always high.
            sel  = 1'b1;
            dout = {w_wheel_nib, 1'b1, ~ps2_mouse[2], ~ps2_mouse[0], ~ps2_mouse[1]};
        end
    end

endmodule

// File: tb/tb_kmouse_port.sv
// Scoreboard bench for kmouse_port: directed packets and reads on a default
// instance and on a SHIFT=2 / INV_Y=1 instance; a monitor checks every probe.
module tb_kmouse_port;

    localparam logic [2:0] A_X   = 3'b011;
    localparam logic [2:0] A_Y   = 3'b111;
    localparam logic [2:0] A_BTN = 3'b010;
`ifdef KMOUSE_WHEEL_EN
    localparam bit WHEEL_ON = 1'b1;
`else
    localparam bit WHEEL_ON = 1'b0;
`endif

    typedef struct packed {
        logic [95:0] name;
        logic [8:0]  req;     // {sel, dout}
    } exp_t;

    logic        clk;
    logic        rst0, rst1;
    logic [24:0] mouse0, mouse1;
    logic [15:0] ext0;
    logic        mode0, rd0;
    logic [2:0]  addr0, addr1;
    logic        sel0, sel1;
    logic [7:0]  dout0, dout1;
    logic        probe0, probe1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    int   checks = 0;
    int   errors = 0;

    kmouse_port u_dut (
        .clk_sys       (clk),
        .reset         (rst0),
        .ps2_mouse     (mouse0),
        .ps2_mouse_ext (ext0),
        .mode          (mode0),
        .addr          (addr0),
        .rd            (rd0),
        .sel           (sel0),
        .dout          (dout0)
    );

    kmouse_port #(.CNT_W(12), .SHIFT(2), .INV_Y(1), .RESET_DX(128)) u_dut_s2 (
        .clk_sys       (clk),
        .reset         (rst1),
        .ps2_mouse     (mouse1),
        .ps2_mouse_ext (16'h0000),
        .mode          (1'b0),
        .addr          (addr1),
        .rd            (1'b0),
        .sel           (sel1),
        .dout          (dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [95:0] name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got sel=%0b dout=%02h required sel=%0b dout=%02h",
                     name, act[8], act[7:0], req[8], req[7:0]);
        end
    endtask

    // Monitor: every probed cycle pops one expectation and compares at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (probe0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0_probe no expectation queued");
                end else begin
                    m0 = q0.pop_front();
                    check(m0.name, {sel0, dout0}, m0.req);
                end
            end
            if (probe1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1_probe no expectation queued");
                end else begin
                    m1 = q1.pop_front();
                    check(m1.name, {sel1, dout1}, m1.req);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [24:0] mk_pkt(input logic tog, input logic [8:0] x,
                                           input logic [8:0] y, input logic [2:0] b);
        return {tog, y[7:0], x[7:0], 2'b00, y[8], x[8], 1'b0, b};
    endfunction

    function automatic logic [8:0] btn_exp(input logic [3:0] whl, input logic [2:0] low);
        return {1'b1, (WHEEL_ON ? whl : 4'hF), 1'b1, low};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt0(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b,
                        input logic [7:0] w);
        mouse0 = mk_pkt(~mouse0[24], x, y, b);
        ext0   = {8'h00, w};
        tick();
    endtask

    task automatic pkt1(input logic [8:0] x, input logic [8:0] y);
        mouse1 = mk_pkt(~mouse1[24], x, y, 3'b000);
        tick();
    endtask

    task automatic read0(input logic [95:0] nm, input logic [2:0] a, input logic r,
                         input logic [8:0] req);
        exp_t e;
        e.name = nm;
        e.req  = req;
        q0.push_back(e);
        addr0  = a;
        rd0    = r;
        probe0 = 1'b1;
        tick();
        probe0 = 1'b0;
        rd0    = 1'b0;
    endtask

    task automatic read1(input logic [95:0] nm, input logic [2:0] a, input logic [8:0] req);
        exp_t e;
        e.name = nm;
        e.req  = req;
        q1.push_back(e);
        addr1  = a;
        probe1 = 1'b1;
        tick();
        probe1 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        mouse0 = '0; mouse1 = '0; ext0 = '0;
        mode0 = 1'b0; rd0 = 1'b0;
        addr0 = '0; addr1 = '0;
        probe0 = 1'b0; probe1 = 1'b0;
        tick(); tick();

        // Reset state and decode
        read0("rst_x",     A_X, 1'b0, 9'h180);
        rst0 = 1'b0;
        read0("rst_y",     A_Y,    1'b0, 9'h100);
        read0("rst_btn",   A_BTN,  1'b0, btn_exp(4'h0, 3'b111));
        read0("btn_110",   3'b110, 1'b0, btn_exp(4'h0, 3'b111));
        read0("miss_000",  3'b000, 1'b0, 9'h0FF);
        read0("miss_001",  3'b001, 1'b0, 9'h0FF);
        read0("miss_101",  3'b101, 1'b0, 9'h0FF);

        // Absolute mode, back-to-back packets and wrap
        repeat (3) pkt0(9'h010, 9'h000, 3'b000, 8'h00);
        read0("abs_x_b0",  A_X, 1'b0, 9'h1B0);
        read0("abs_y_idle", A_Y, 1'b0, 9'h100);
        pkt0(9'h050, 9'h000, 3'b000, 8'h00);
        read0("abs_x_00",  A_X, 1'b0, 9'h100);
        pkt0(9'h1C0, 9'h000, 3'b000, 8'h00);
        read0("abs_x_c0",  A_X, 1'b0, 9'h1C0);
        pkt0(9'h000, 9'h1FF, 3'b000, 8'h00);
        read0("abs_y_ff",  A_Y, 1'b0, 9'h1FF);

        // Buttons
        pkt0(9'h000, 9'h000, 3'b001, 8'h00);
        read0("btn_left",  A_BTN, 1'b0, btn_exp(4'h0, 3'b101));
        pkt0(9'h000, 9'h000, 3'b010, 8'h00);
        read0("btn_right", A_BTN, 1'b0, btn_exp(4'h0, 3'b110));
        pkt0(9'h000, 9'h000, 3'b100, 8'h00);
        read0("btn_mid",   A_BTN, 1'b0, btn_exp(4'h0, 3'b011));

        // Wheel
        pkt0(9'h000, 9'h000, 3'b000, 8'h03);
        pkt0(9'h000, 9'h000, 3'b000, 8'hFF);
        read0("wheel_2",   A_BTN, 1'b0, btn_exp(4'h2, 3'b111));
        repeat (15) pkt0(9'h000, 9'h000, 3'b000, 8'h01);
        read0("wheel_wrap", A_BTN, 1'b0, btn_exp(4'h1, 3'b111));

        // Packet coinciding with reset is dropped
        ext0   = 16'h0000;
        rst0   = 1'b1;
        mouse0 = mk_pkt(~mouse0[24], 9'h010, 9'h000, 3'b000);
        tick(); tick();
        rst0 = 1'b0;
        tick();
        read0("midrst_x",   A_X,   1'b0, 9'h180);
        read0("midrst_btn", A_BTN, 1'b0, btn_exp(4'h0, 3'b111));

        // Delta mode: saturation and clear-on-read
        mode0 = 1'b1;
        read0("dlt_x_0",   A_X, 1'b0, 9'h100);
        pkt0(9'h064, 9'h000, 3'b000, 8'h00);
        pkt0(9'h064, 9'h000, 3'b000, 8'h00);
        read0("dlt_sat_p", A_X, 1'b1, 9'h17F);
        read0("dlt_clr",   A_X, 1'b0, 9'h100);
        pkt0(9'h19C, 9'h000, 3'b000, 8'h00);
        pkt0(9'h19C, 9'h000, 3'b000, 8'h00);
        read0("dlt_sat_n", A_X, 1'b1, 9'h180);
        pkt0(9'h000, 9'h005, 3'b000, 8'h00);
        read0("dlt_y_5",   A_Y, 1'b1, 9'h105);
        read0("dlt_y_clr", A_Y, 1'b0, 9'h100);

        // Mode change keeps delta contents; accumulator kept running
        pkt0(9'h007, 9'h000, 3'b000, 8'h00);
        mode0 = 1'b0;
        read0("mode_abs_x", A_X, 1'b0, 9'h187);
        mode0 = 1'b1;
        read0("mode_dlt_x", A_X, 1'b0, 9'h107);

        // Read and packet on the same edge
        mouse0 = mk_pkt(~mouse0[24], 9'h005, 9'h000, 3'b000);
        addr0  = A_X;
        rd0    = 1'b1;
        tick();
        rd0 = 1'b0;
        read0("rd_pkt_x",  A_X, 1'b0, 9'h105);

        // SHIFT=2, INV_Y=1 instance
        rst1 = 1'b0;
        tick();
        read1("s2_rst_x",  A_X, 9'h180);
        repeat (3) pkt1(9'h001, 9'h000);
        read1("s2_x_3",    A_X, 9'h180);
        pkt1(9'h001, 9'h000);
        read1("s2_x_4",    A_X, 9'h181);
        pkt1(9'h000, 9'h004);
        read1("s2_inv_y",  A_Y, 9'h1FF);
        pkt1(9'h000, 9'h1F8);
        read1("s2_inv_y2", A_Y, 9'h101);

        repeat (3) tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending required 0", q0.size() + q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
